// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and sequencer states.
package muldiv_pkg;

  localparam int unsigned MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } md_state_e;

  // Signed variants treat both operands as two's complement.
  function automatic logic md_is_signed(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_compute.sv
// Single-shot combinational multiply/divide: produces the {hi,lo} result of an op,
// including the divide-by-zero and signed-overflow corner cases.
module muldiv_compute
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [MD_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]   src_a_i,
  input  logic [WIDTH-1:0]   src_b_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             sgn;
  logic [W2-1:0]    ext_a;
  logic [W2-1:0]    ext_b;
  logic [W2-1:0]    prod;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] safe_b;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_zero;

  assign sgn = md_is_signed(op_i);

  // Extending to 2*WIDTH and keeping the low 2*WIDTH bits gives the exact signed
  // or unsigned product with a single unsigned multiplier.
  assign ext_a = sgn ? {{WIDTH{src_a_i[WIDTH-1]}}, src_a_i} : {{WIDTH{1'b0}}, src_a_i};
  assign ext_b = sgn ? {{WIDTH{src_b_i[WIDTH-1]}}, src_b_i} : {{WIDTH{1'b0}}, src_b_i};
  assign prod  = ext_a * ext_b;

  // Division is done on magnitudes so no signed divide can ever overflow; the
  // most-negative / -1 case then falls out as quotient = most-negative, rem = 0.
  assign neg_a    = sgn & src_a_i[WIDTH-1];
  assign neg_b    = sgn & src_b_i[WIDTH-1];
  assign mag_a    = neg_a ? ('0 - src_a_i) : src_a_i;
  assign mag_b    = neg_b ? ('0 - src_b_i) : src_b_i;
  assign div_zero = (src_b_i == '0);
  assign safe_b   = div_zero ? ONE : mag_b;
  assign q_mag    = mag_a / safe_b;
  assign r_mag    = mag_a % safe_b;
  assign quot     = (neg_a ^ neg_b) ? ('0 - q_mag) : q_mag;
  assign rem      = neg_a ? ('0 - r_mag) : r_mag;

  // Select the result for the requested op; non-arithmetic ops yield zero.
  always_comb begin
    hi_o = '0;
    lo_o = '0;
    case (op_i)
      MD_MULT, MD_MULTU: begin
        hi_o = prod[W2-1:WIDTH];
        lo_o = prod[WIDTH-1:0];
      end
      MD_DIV, MD_DIVU: begin
        if (div_zero) begin
          hi_o = src_a_i;
          lo_o = '1;
        end else begin
          hi_o = rem;
          lo_o = quot;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. The result is computed
// at acceptance, held pending, and committed after the configured latency.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               flush,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             accept;

  muldiv_compute #(
    .WIDTH(WIDTH)
  ) u_compute (
    .op_i   (op),
    .src_a_i(src_a),
    .src_b_i(src_b),
    .hi_o   (res_hi),
    .lo_o   (res_lo)
  );

  assign accept = start && (state_q == ST_IDLE) && !flush;

  // Next-state logic: acceptance, latency countdown, commit and flush abort.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            MD_MTHI: hi_d = src_a;
            MD_MTLO: lo_d = src_a;
            MD_MULT, MD_MULTU: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              cnt_d     = MULT_LOAD;
              state_d   = ST_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              cnt_d     = DIV_LOAD;
              state_d   = ST_BUSY;
            end
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          pend_hi_d = '0;
          pend_lo_d = '0;
        end else if (cnt_q == '0) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: transaction-level reference model, per-cycle compare,
// directed corner cases with literal expectations, then randomized traffic.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned T_MULT = 5;
  localparam int unsigned T_DIV  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass;
  int n_total;
  bit cmp_en;

  muldiv_unit #(
    .WIDTH(32),
    .MULT_CYCLES(T_MULT),
    .DIV_CYCLES(T_DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .src_a(src_a),
    .src_b(src_b),
    .flush(flush),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference arithmetic straight from the rules, using 64-bit integers.
  function automatic logic [63:0] ref_calc(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      MD_MULT:  return sa * sb;
      MD_MULTU: return ua * ub;
      MD_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Transaction model: remaining busy cycles, pending result, architectural HI/LO.
  int unsigned m_left;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left = 0;
      m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
    end else if (m_left != 0) begin
      if (flush) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_hi = m_phi;
          m_lo = m_plo;
        end
      end
    end else if (start && !flush) begin
      case (op)
        MD_MTHI: m_hi = src_a;
        MD_MTLO: m_lo = src_a;
        MD_MULT, MD_MULTU: begin
          {m_phi, m_plo} = ref_calc(op, src_a, src_b);
          m_left = T_MULT;
        end
        MD_DIV, MD_DIVU: begin
          {m_phi, m_plo} = ref_calc(op, src_a, src_b);
          m_left = T_DIV;
        end
        default: ;
      endcase
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (cmp_en && reset) begin
      chk("busy", {63'd0, busy}, {63'd0, (m_left != 0)});
      chk("hi", {32'd0, hi}, {32'd0, m_hi});
      chk("lo", {32'd0, lo}, {32'd0, m_lo});
    end
  end

  // Drive one cycle of inputs (called at a negedge, returns at the next negedge).
  task automatic step(input bit st, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input bit fl);
    start = st; op = o; src_a = a; src_b = b; flush = fl;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic run_to_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    end
    if (n >= 100) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    n_pass = 0; n_total = 0; cmp_en = 1'b0;
    reset = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; flush = 1'b0;

    // Model pins against hand-computed values.
    chk("ref_mult", ref_calc(MD_MULT, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
    chk("ref_multu", ref_calc(MD_MULTU, 32'hFFFF_FFFF, 32'd2), 64'h0000_0001_FFFF_FFFE);
    chk("ref_div", ref_calc(MD_DIV, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("ref_divu0", ref_calc(MD_DIVU, 32'd7, 32'd0), 64'h0000_0007_FFFF_FFFF);

    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    reset = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // MTHI/MTLO take effect next cycle without busy.
    step(1'b1, MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    chk("mthi_hi", {32'd0, hi}, 64'h1234_5678);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    step(1'b1, MD_MTLO, 32'h2222_2222, 32'd0, 1'b0);
    chk("mtlo_lo", {32'd0, lo}, 64'h2222_2222);

    // Signed multiply with an ignored start during busy; old values held.
    step(1'b1, MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      chk("mult_hold_hi", {32'd0, hi}, 64'h1234_5678);
      chk("mult_hold_lo", {32'd0, lo}, 64'h2222_2222);
      step(n == 2, MD_MULT, 32'd7, 32'd7, 1'b0);
    end
    chk("mult_lat", 64'(n), 64'd5);
    chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    chk("mult_lo", {32'd0, lo}, 64'hFFFF_FFF1);

    // Back-to-back issue in the first non-busy cycle.
    step(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    run_to_idle(n);
    chk("multu_lat", 64'(n), 64'd5);
    chk("multu_hi", {32'd0, hi}, 64'h0000_0001);
    chk("multu_lo", {32'd0, lo}, 64'hFFFF_FFFE);

    step(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_to_idle(n);
    chk("div_lat", 64'(n), 64'd10);
    chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);

    step(1'b1, MD_DIVU, 32'd7, 32'd0, 1'b0);
    run_to_idle(n);
    chk("divz_hi", {32'd0, hi}, 64'h0000_0007);
    chk("divz_lo", {32'd0, lo}, 64'hFFFF_FFFF);

    step(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_to_idle(n);
    chk("ovf_hi", {32'd0, hi}, 64'h0);
    chk("ovf_lo", {32'd0, lo}, 64'h8000_0000);

    // Flush in busy cycle 3 of a divide.
    step(1'b1, MD_MTHI, 32'hAAAA_AAAA, 32'd0, 1'b0);
    step(1'b1, MD_MTLO, 32'hBBBB_BBBB, 32'd0, 1'b0);
    step(1'b1, MD_DIV, 32'd100, 32'd3, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("flush_pre_busy", {63'd0, busy}, 64'd1);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_hi", {32'd0, hi}, 64'hAAAA_AAAA);
    chk("flush_lo", {32'd0, lo}, 64'hBBBB_BBBB);

    // flush with start drops the start, including MTHI.
    step(1'b1, MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
    chk("fs_mthi_hi", {32'd0, hi}, 64'hAAAA_AAAA);
    step(1'b1, MD_MULT, 32'd3, 32'd3, 1'b1);
    chk("fs_mult_busy", {63'd0, busy}, 64'd0);

    // Flush on the final busy cycle suppresses the commit.
    step(1'b1, MD_MULT, 32'd3, 32'd3, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("last_pre_busy", {63'd0, busy}, 64'd1);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("last_busy", {63'd0, busy}, 64'd0);
    chk("last_lo", {32'd0, lo}, 64'hBBBB_BBBB);

    // Illegal op is ignored.
    step(1'b1, 3'd6, 32'h5555_5555, 32'd1, 1'b0);
    chk("illegal_busy", {63'd0, busy}, 64'd0);
    chk("illegal_hi", {32'd0, hi}, 64'hAAAA_AAAA);

    // Asynchronous reset mid-multiply.
    step(1'b1, MD_MULT, 32'd9, 32'd9, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_hi", {32'd0, hi}, 64'd0);
    chk("arst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), pick(), pick(),
           $urandom_range(0, 24) == 0);
    end
    run_to_idle(n);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
